// File: rtl/rx_iq_stream_scheduler.sv
// rx_iq_stream_scheduler: buffers DDC RX1/RX2 IQ sets in a circular FIFO and streams them big-endian, one byte per bus request.
module rx_iq_stream_scheduler #(
   parameter int DEPTH    = 8,
   parameter int AW       = 3,
   parameter int SAMPLE_W = 32
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                iq_valid,
   input  logic [SAMPLE_W-1:0] rx1_i,
   input  logic [SAMPLE_W-1:0] rx1_q,
   input  logic [SAMPLE_W-1:0] rx2_i,
   input  logic [SAMPLE_W-1:0] rx2_q,
   input  logic                rx2_en,
   input  logic                stream_start,
   input  logic                stream_stop,
   input  logic                byte_req,
   input  logic                cnt_clear,
   output logic [7:0]          byte_out,
   output logic                byte_valid,
   output logic [AW:0]         fifo_level,
   output logic [15:0]         overflow_cnt,
   output logic [15:0]         underflow_cnt,
   output logic                streaming
);
   localparam int FW = 4 * SAMPLE_W;
   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
   state_t state_q, state_d;
   logic [FW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] level_q, level_d;
   logic [FW-1:0] hold_q, hold_d, seq;
   logic [3:0] idx_q, idx_d, ridx;
   logic pend_q, pend_d, frame_rx2_q, frame_rx2_d;
   logic [7:0] byte_out_q, byte_out_d, byte_sel;
   logic byte_valid_q, byte_valid_d, streaming_q, streaming_d;
   logic [15:0] ovf_q, ovf_d, unf_q, unf_d;
   logic empty, full, load, pop, push, serve, last;
   // Entries hold {I1,Q1,I2,Q2}; the wire order puts each Q word before its I word.
   always_comb begin
      empty = level_q == '0;
      full = level_q == (AW+1)'(DEPTH);
      load = state_q == LOAD && !stream_stop && !stream_start;
      pop = load && !empty;
      push = iq_valid && (!full || pop);
      serve = state_q == SEND && !stream_stop && !stream_start && (byte_req || pend_q);
      last = idx_q == (frame_rx2_q ? 4'd15 : 4'd7);
      seq = {hold_q[2*SAMPLE_W +: SAMPLE_W], hold_q[3*SAMPLE_W +: SAMPLE_W],
             hold_q[0 +: SAMPLE_W], hold_q[SAMPLE_W +: SAMPLE_W]};
      ridx = ~idx_q;
      byte_sel = seq[{ridx, 3'b000} +: 8];
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_d = cnt_clear ? '0 : (iq_valid && !push && ovf_q != '1) ? ovf_q + 16'd1 : ovf_q;
      unf_d = cnt_clear ? '0 : (load && empty && unf_q != '1) ? unf_q + 16'd1 : unf_q;
      state_d = state_q;
      pend_d = pend_q;
      idx_d = idx_q;
      hold_d = hold_q;
      frame_rx2_d = frame_rx2_q;
      byte_out_d = byte_out_q;
      byte_valid_d = 1'b0;
      if (stream_stop) begin
         state_d = IDLE;
         pend_d = 1'b0;
      end else if (stream_start) begin
         state_d = LOAD;
         pend_d = 1'b0;
      end else if (state_q == LOAD) begin
         state_d = SEND;
         idx_d = '0;
         frame_rx2_d = rx2_en;
         pend_d = byte_req;
         hold_d = empty ? hold_q : mem_q[rd_ptr_q];
      end else if (serve) begin
         byte_out_d = byte_sel;
         byte_valid_d = 1'b1;
         idx_d = idx_q + 4'd1;
         pend_d = 1'b0;
         state_d = last ? LOAD : SEND;
      end
      streaming_d = state_d != IDLE;
   end
   always_ff @(posedge clk_in) begin
      if (push)
         mem_q[wr_ptr_q] <= {rx1_i, rx1_q, rx2_i, rx2_q};
   end
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q <= '0;
         hold_q <= '0;
         idx_q <= '0;
         pend_q <= 1'b0;
         frame_rx2_q <= 1'b0;
         byte_out_q <= '0;
         byte_valid_q <= 1'b0;
         streaming_q <= 1'b0;
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q <= level_d;
         hold_q <= hold_d;
         idx_q <= idx_d;
         pend_q <= pend_d;
         frame_rx2_q <= frame_rx2_d;
         byte_out_q <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         streaming_q <= streaming_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end
   assign byte_out = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign fifo_level = level_q;
   assign overflow_cnt = ovf_q;
   assign underflow_cnt = unf_q;
   assign streaming = streaming_q;
endmodule

// File: tb/tb_rx_iq_stream_scheduler.sv
// tb_rx_iq_stream_scheduler: queue-based reference model checked every cycle, plus directed literal checks and a random soak.
module tb_rx_iq_stream_scheduler;
   localparam int DEPTH = 8;
   localparam int AW = 3;
   logic clk_in = 1'b0, reset = 1'b1, iq_valid = 1'b0, rx2_en = 1'b0;
   logic stream_start = 1'b0, stream_stop = 1'b0, byte_req = 1'b0, cnt_clear = 1'b0;
   logic [31:0] rx1_i = '0, rx1_q = '0, rx2_i = '0, rx2_q = '0;
   logic [7:0] byte_out;
   logic byte_valid, streaming;
   logic [AW:0] fifo_level;
   logic [15:0] overflow_cnt, underflow_cnt;
   int n_cmp = 0, n_bad = 0;
   bit chk_on = 1'b0;
   always #5 clk_in = ~clk_in;
   rx_iq_stream_scheduler #(.DEPTH(DEPTH), .AW(AW), .SAMPLE_W(32)) dut (
      .clk_in(clk_in), .reset(reset), .iq_valid(iq_valid),
      .rx1_i(rx1_i), .rx1_q(rx1_q), .rx2_i(rx2_i), .rx2_q(rx2_q),
      .rx2_en(rx2_en), .stream_start(stream_start), .stream_stop(stream_stop),
      .byte_req(byte_req), .cnt_clear(cnt_clear), .byte_out(byte_out),
      .byte_valid(byte_valid), .fifo_level(fifo_level), .overflow_cnt(overflow_cnt),
      .underflow_cnt(underflow_cnt), .streaming(streaming)
   );
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Reference model: mode 0 idle, 1 load, 2 send; frames are byte queues.
   logic [127:0] m_fifo[$];
   logic [127:0] m_hold = '0;
   logic [7:0] m_frame[$];
   logic [31:0] m_w[4];
   int m_mode = 0, m_ovf = 0, m_unf = 0;
   bit m_pend = 0, m_bv = 0, m_act = 0;
   logic [7:0] m_byte = '0;
   always @(posedge clk_in) begin
      if (reset) begin
         m_fifo.delete(); m_frame.delete();
         m_hold = '0; m_mode = 0; m_pend = 0; m_byte = '0; m_bv = 0; m_ovf = 0; m_unf = 0;
      end else begin
         m_bv = 0;
         m_act = m_mode == 1 && !stream_stop && !stream_start;
         if (m_act) begin
            if (m_fifo.size() > 0) m_hold = m_fifo.pop_front();
            else if (m_unf < 65535) m_unf++;
         end
         if (iq_valid) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back({rx1_i, rx1_q, rx2_i, rx2_q});
            else if (m_ovf < 65535) m_ovf++;
         end
         if (cnt_clear) begin m_ovf = 0; m_unf = 0; end
         if (stream_stop) begin
            m_mode = 0; m_pend = 0;
         end else if (stream_start) begin
            m_mode = 1; m_pend = 0;
         end else if (m_mode == 1) begin
            m_w[0] = m_hold[95:64]; m_w[1] = m_hold[127:96];
            m_w[2] = m_hold[31:0];  m_w[3] = m_hold[63:32];
            m_frame.delete();
            for (int k = 0; k < (rx2_en ? 4 : 2); k++)
               for (int b = 3; b >= 0; b--) m_frame.push_back(m_w[k][8*b +: 8]);
            m_pend = byte_req;
            m_mode = 2;
         end else if (m_mode == 2 && (byte_req || m_pend)) begin
            m_byte = m_frame.pop_front();
            m_bv = 1; m_pend = 0;
            if (m_frame.size() == 0) m_mode = 1;
         end
      end
   end
   always @(negedge clk_in) begin
      if (chk_on) begin
         chk("byte_valid", int'(byte_valid), int'(m_bv));
         chk("byte_out", int'(byte_out), int'(m_byte));
         chk("fifo_level", int'(fifo_level), m_fifo.size());
         chk("overflow_cnt", int'(overflow_cnt), m_ovf);
         chk("underflow_cnt", int'(underflow_cnt), m_unf);
         chk("streaming", int'(streaming), int'(m_mode != 0));
      end
   end
   logic [7:0] got[$];
   always @(negedge clk_in) if (byte_valid) got.push_back(byte_out);
   function automatic int gb(input int k);
      return k < got.size() ? int'(got[k]) : -1;
   endfunction
   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk_in); #1; end
   endtask
   task automatic push(input logic [31:0] i1, q1, i2, q2);
      rx1_i = i1; rx1_q = q1; rx2_i = i2; rx2_q = q2;
      iq_valid = 1'b1; tick(); iq_valid = 1'b0;
   endtask
   task automatic pulse_start; stream_start = 1'b1; tick(); stream_start = 1'b0; endtask
   task automatic pulse_stop; stream_stop = 1'b1; tick(); stream_stop = 1'b0; endtask
   task automatic pulse_clear; cnt_clear = 1'b1; tick(); cnt_clear = 1'b0; endtask
   task automatic reqs(input int n, input int gap);
      repeat (n) begin byte_req = 1'b1; tick(); byte_req = 1'b0; tick(gap - 1); end
   endtask
   logic [7:0] e1[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   logic [7:0] e2[8] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
   int since, gap;
   initial begin
      tick(); chk_on = 1'b1; tick(2);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_streaming", int'(streaming), 0);
      reset = 1'b0;
      // single RX1 frame
      push(32'h55667788, 32'h11223344, 32'h0, 32'h0);
      chk("t1_level_push", int'(fifo_level), 1);
      got.delete(); pulse_start; tick();
      chk("t1_level_pop", int'(fifo_level), 0);
      reqs(8, 4);
      chk("t1_count", got.size(), 8);
      for (int k = 0; k < 8; k++) chk($sformatf("t1_byte%0d", k), gb(k), int'(e1[k]));
      // RX1+RX2 frame
      pulse_stop; rx2_en = 1'b1;
      push(32'h01020304, 32'h05060708, 32'hB1B2B3B4, 32'hA1A2A3A4);
      got.delete(); pulse_start; tick(); reqs(16, 3);
      chk("t2_count", got.size(), 16);
      for (int k = 0; k < 8; k++) chk($sformatf("t2_byte%0d", k + 8), gb(k + 8), int'(e2[k]));
      // overflow with no stream
      pulse_stop; rx2_en = 1'b0; pulse_clear;
      for (int k = 0; k < DEPTH + 3; k++) push(32'(k), 32'hC0DE0000 + 32'(k), 32'h0, 32'h0);
      chk("t3_level", int'(fifo_level), DEPTH);
      chk("t3_ovf", int'(overflow_cnt), 3);
      got.delete(); pulse_start; tick(); reqs(8 * DEPTH, 2);
      chk("t3_count", got.size(), 8 * DEPTH);
      chk("t3_first", gb(0), 8'hC0);
      chk("t3_set0_lsb", gb(3), 8'h00);
      chk("t3_set7_lsb", gb(59), 8'h07);
      // underflow repeats and clear-vs-increment
      pulse_stop; pulse_clear;
      got.delete(); pulse_start; reqs(15, 4);
      byte_req = 1'b1; tick(); byte_req = 1'b0;
      chk("t4_unf", int'(underflow_cnt), 2);
      cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
      chk("t4_unf_clr", int'(underflow_cnt), 0);
      chk("t4_rep1", gb(3), 8'h07);
      chk("t4_rep2", gb(11), 8'h07);
      // push on a full FIFO while LOAD pops
      pulse_stop;
      for (int k = 0; k < DEPTH; k++) push(32'(k), {8'h50 + 8'(k), 24'h0}, 32'h0, 32'h0);
      pulse_start;
      rx1_q = 32'h58000000; iq_valid = 1'b1; tick(); iq_valid = 1'b0;
      chk("t5_level", int'(fifo_level), DEPTH);
      chk("t5_ovf", int'(overflow_cnt), 0);
      // stop/restart mid-frame, then reset mid-SEND
      got.delete(); reqs(4, 3);
      pulse_stop; pulse_start; tick(); reqs(1, 3);
      chk("t6_first", gb(0), 8'h50);
      chk("t6_restart", gb(4), 8'h51);
      reqs(2, 3);
      byte_req = 1'b1; tick(); reset = 1'b1; byte_req = 1'b0; tick();
      chk("t6_rst_streaming", int'(streaming), 0);
      chk("t6_rst_level", int'(fifo_level), 0);
      reset = 1'b0;
      // random soak
      since = 0; gap = 2;
      pulse_start;
      for (int c = 0; c < 6000; c++) begin
         iq_valid = ($urandom % 3) == 0;
         rx1_i = $urandom; rx1_q = $urandom; rx2_i = $urandom; rx2_q = $urandom;
         if (($urandom % 50) == 0) rx2_en = $urandom % 2;
         stream_start = ($urandom % 150) == 0;
         stream_stop = ($urandom % 250) == 0;
         cnt_clear = ($urandom % 400) == 0;
         reset = ($urandom % 2000) == 0;
         since++;
         byte_req = since >= gap;
         if (byte_req) begin since = 0; gap = $urandom_range(2, 5); end
         tick();
      end
      {iq_valid, stream_start, stream_stop, cnt_clear, reset, byte_req} = '0;
      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
